// File: rtl/general_mul_add.sv
// general_mul_add: sequential shift-add multiply-accumulate, P = Q*B + R.
//   Latency: WIDTH_Q+1 cycles from the accepted start edge to DONE; throughput 1 op per WIDTH_Q+2 cycles.
//   Backpressure: none; a start seen while BUSY is dropped, not queued.
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   start           - request, sampled only while idle
//   Q, B, R         - multiplier, multiplicand and addend, captured when start is accepted
//   P               - result, updated only on completion (cleared by reset)
//   DONE            - one-cycle pulse; P is valid from this cycle on
//   BUSY            - high while an operation is in flight
module general_mul_add #(
  parameter int WIDTH_Q = 4,
  parameter int WIDTH_B = 4,
  parameter int WIDTH_A = WIDTH_Q + WIDTH_B
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH_Q-1:0] Q,
  input  logic [WIDTH_B-1:0] B,
  input  logic [WIDTH_B-1:0] R,
  output logic [WIDTH_A-1:0] P,
  output logic               DONE,
  output logic               BUSY
);

  // count must hold the value WIDTH_Q itself.
  localparam int CW = $clog2(WIDTH_Q + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH_Q-1:0] q_sh;
  logic [WIDTH_A-1:0] b_sh;
  logic [WIDTH_A-1:0] acc;
  logic [CW-1:0]      count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      count <= '0;
      P     <= '0;
      DONE  <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Width casts zero-extend (or truncate when WIDTH_A is overridden smaller).
            q_sh  <= Q;
            b_sh  <= WIDTH_A'(B);
            acc   <= WIDTH_A'(R);
            count <= CW'(WIDTH_Q);
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // One multiplier bit per cycle, LSB first; no early exit so timing is operand-independent.
          if (q_sh[0]) begin
            acc <= acc + b_sh;
          end
          b_sh  <= b_sh << 1;
          q_sh  <= q_sh >> 1;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          P     <= acc;
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_general_mul_add.sv
// Self-checking bench for general_mul_add with default widths (Q=4, B=4, A=8).
// Reference model: P = (Q*B + R) mod 2^8, and divider model Q = A/B, R = A%B for closed loop.
module tb_general_mul_add;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] Q;
  logic [3:0] B;
  logic [3:0] R;
  logic [7:0] P;
  logic       DONE;
  logic       BUSY;

  int errors = 0;
  int checks = 0;

  general_mul_add dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Q     (Q),
    .B     (B),
    .R     (R),
    .P     (P),
    .DONE  (DONE),
    .BUSY  (BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input int q, input int b, input int r);
    int full;
    full = q * b + r;
    return 8'(full % 256);
  endfunction

  // Advance one clock; afterwards we sit 1ns past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and wait (bounded) for DONE.
  // lat = edges from accept to DONE (-1 on timeout); busy_n = cycles BUSY was seen high.
  task automatic do_op(input logic [3:0] q, input logic [3:0] b, input logic [3:0] r,
                       output logic [7:0] p, output int lat, output int busy_n);
    Q = q; B = b; R = r; start = 1'b1;
    step();
    start = 1'b0;
    lat = -1;
    busy_n = 0;
    p = P;
    for (int i = 1; i <= 20; i++) begin
      if (BUSY) busy_n++;
      step();
      if (DONE) begin
        lat = i;
        p = P;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; Q = '0; B = '0; R = '0;
    step();
    step();
    checks++;
    if (P !== 8'd0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset: P=%0d DONE=%b BUSY=%b, required P=0 DONE=0 BUSY=0", P, DONE, BUSY);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] p;
    int lat, bn;
    do_op(4'd5, 4'd3, 4'd0, p, lat, bn);
    checks++;
    if (p !== model(5, 3, 0)) begin
      errors++; $display("FAIL basic_p: got %0d required %0d", p, model(5, 3, 0));
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL basic_latency: got %0d required 5", lat);
    end
    checks++;
    if (bn !== 5) begin
      errors++; $display("FAIL basic_busy_cycles: got %0d required 5", bn);
    end
  endtask

  task automatic test_hold();
    int lat;
    logic [7:0] p;
    Q = 4'd4; B = 4'd3; R = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    Q = 4'd0; B = 4'd0; R = 4'd0;
    lat = -1;
    p = P;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (DONE) begin lat = i; p = P; break; end
    end
    checks++;
    if (lat !== 5 || p !== model(4, 3, 3)) begin
      errors++; $display("FAIL hold_result: P=%0d lat=%0d, required P=%0d lat=5", p, lat, model(4, 3, 3));
    end
    step();
    checks++;
    if (DONE !== 1'b0) begin
      errors++; $display("FAIL hold_done_width: DONE=%b one cycle later, required 0", DONE);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (P !== 8'd15 || DONE !== 1'b0) begin
        errors++; $display("FAIL hold_idle[%0d]: P=%0d DONE=%b, required P=15 DONE=0", i, P, DONE);
      end
    end
  endtask

  task automatic test_extremes();
    logic [3:0] tq [3] = '{4'hF, 4'h0, 4'hF};
    logic [3:0] tb [3] = '{4'hF, 4'hF, 4'h0};
    logic [3:0] tr [3] = '{4'hE, 4'h9, 4'h0};
    logic [7:0] texp [3] = '{8'd239, 8'd9, 8'd0};
    logic [7:0] p;
    int lat, bn;
    for (int i = 0; i < 3; i++) begin
      do_op(tq[i], tb[i], tr[i], p, lat, bn);
      checks++;
      if (p !== texp[i] || lat !== 5) begin
        errors++;
        $display("FAIL extreme[%0d]: P=%0d lat=%0d, required P=%0d lat=5", i, p, lat, texp[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    logic [7:0] plast;
    Q = 4'd6; B = 4'd7; R = 4'd1; start = 1'b1;
    step();                                  // accept edge
    start = 1'b0;
    step();                                  // now in 2nd RUN cycle
    Q = 4'd1; B = 4'd1; R = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    plast = P;
    for (int i = 0; i < 15; i++) begin
      step();
      if (DONE) begin ndone++; plast = P; end
    end
    checks++;
    if (ndone !== 1) begin
      errors++; $display("FAIL ignore_done_count: got %0d required 1", ndone);
    end
    checks++;
    if (plast !== model(6, 7, 1)) begin
      errors++; $display("FAIL ignore_p: got %0d required %0d", plast, model(6, 7, 1));
    end
  endtask

  task automatic test_back_to_back();
    int t, ndone;
    int td [2];
    logic [7:0] pd [2];
    Q = 4'd2; B = 4'd3; R = 4'd1; start = 1'b1;
    step();
    Q = 4'd3; B = 4'd3; R = 4'd0;
    t = 0;
    ndone = 0;
    td = '{0, 0};
    pd = '{8'd0, 8'd0};
    for (int i = 0; i < 30; i++) begin
      step();
      t++;
      if (DONE) begin
        td[ndone] = t;
        pd[ndone] = P;
        ndone++;
        if (ndone == 2) break;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 2) begin
      errors++; $display("FAIL b2b_done_count: got %0d required 2", ndone);
    end
    checks++;
    if (td[1] - td[0] !== 6) begin
      errors++; $display("FAIL b2b_spacing: got %0d required 6", td[1] - td[0]);
    end
    checks++;
    if (pd[0] !== model(2, 3, 1) || pd[1] !== model(3, 3, 0)) begin
      errors++;
      $display("FAIL b2b_p: got %0d,%0d required %0d,%0d", pd[0], pd[1], model(2, 3, 1), model(3, 3, 0));
    end
    step();
    step();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_after: BUSY=%b required 0", BUSY);
    end
  endtask

  task automatic test_mid_reset();
    int ndone, lat, bn;
    logic [7:0] p;
    Q = 4'd7; B = 4'd5; R = 4'd2; start = 1'b1;
    step();                                  // accept edge
    start = 1'b0;
    step();
    step();                                  // 3rd RUN cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (P !== 8'd0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++; $display("FAIL midreset_state: P=%0d BUSY=%b DONE=%b, required 0/0/0", P, BUSY, DONE);
    end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (DONE) ndone++;
    end
    checks++;
    if (ndone !== 0 || P !== 8'd0) begin
      errors++; $display("FAIL midreset_quiet: DONEs=%0d P=%0d, required 0 and 0", ndone, P);
    end
    do_op(4'd3, 4'd5, 4'd2, p, lat, bn);
    checks++;
    if (p !== 8'd17 || lat !== 5) begin
      errors++; $display("FAIL midreset_next: P=%0d lat=%0d, required P=17 lat=5", p, lat);
    end
  endtask

  task automatic test_closed_loop();
    logic [7:0] p;
    int lat, bn;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_op(4'(a / b), 4'(b), 4'(a % b), p, lat, bn);
        checks++;
        if (p !== 8'(a) || lat !== 5) begin
          errors++; $display("FAIL closed_loop A=%0d B=%0d: P=%0d lat=%0d, required P=%0d lat=5", a, b, p, lat, a);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] p;
    logic [3:0] q, b, r;
    int lat, bn;
    for (int i = 0; i < 40; i++) begin
      q = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      r = 4'($urandom_range(0, 15));
      do_op(q, b, r, p, lat, bn);
      checks++;
      if (p !== model(q, b, r) || lat !== 5 || bn !== 5) begin
        errors++;
        $display("FAIL random[%0d] Q=%0d B=%0d R=%0d: P=%0d lat=%0d busy=%0d, required P=%0d lat=5 busy=5",
                 i, q, b, r, p, lat, bn, model(q, b, r));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_extremes();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_closed_loop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
